// File: rtl/simple_ram_ex_pkg.sv
// Shared types and constants for the simple_ram_ex buffer.
// Lane count helper maps a word width onto whole byte-enable lanes.
package simple_ram_ex_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int lanes(input int width);
        return (width + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/simple_ram_ex_clr.sv
// Post-reset clear sweep: walks every address once and then parks in IDLE.
// busy stays high for exactly 2**widthad cycles after reset release.
module simple_ram_ex_clr
    import simple_ram_ex_pkg::*;
#(
    parameter int widthad        = 8,
    parameter bit clear_on_reset = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               busy,
    output logic               clr_wren,
    output logic [widthad-1:0] clr_addr
);

    localparam logic [widthad-1:0] LAST_ADDR = '1;
    localparam state_t RST_STATE = clear_on_reset ? ST_CLEAR : ST_IDLE;

    state_t             r_state;
    state_t             w_next;
    logic [widthad-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_CLEAR)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        clr_wren = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                busy     = 1'b1;
                clr_wren = 1'b1;
                if (r_cnt == LAST_ADDR)
                    w_next = ST_IDLE;
            end
            default: ;
        endcase
    end

    assign clr_addr = r_cnt;

endmodule

// File: rtl/simple_ram_ex.sv
// Simple dual-port RAM with byte-lane writes, q_valid strobe and post-reset clear sweep.
// Define SIMPLE_RAM_EX_BYPASS_EN for write-first same-address behaviour (read-first otherwise).
module simple_ram_ex
    import simple_ram_ex_pkg::*;
#(
    parameter int               width          = 32,
    parameter int               widthad        = 8,
    parameter int               out_reg        = 0,
    parameter int               clear_on_reset = 1,
    parameter logic [width-1:0] clear_value    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [widthad-1:0]        wraddress,
    input  logic                      wren,
    input  logic [lanes(width)-1:0]   byteena,
    input  logic [width-1:0]          data,
    input  logic [widthad-1:0]        rdaddress,
    input  logic                      rden,
    output logic [width-1:0]          q,
    output logic                      q_valid,
    output logic                      busy
);

    localparam int DEPTH = 2 ** widthad;

    logic [width-1:0]   r_mem [DEPTH];
    logic               w_busy;
    logic               w_clr_wren;
    logic [widthad-1:0] w_clr_addr;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [width-1:0]   w_wmask;
    logic [width-1:0]   w_rd_word;
    logic [width-1:0]   w_rd_data;
    logic [width-1:0]   r_q1;
    logic               r_v1;

    simple_ram_ex_clr #(
        .widthad        (widthad),
        .clear_on_reset (clear_on_reset != 0)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .busy     (w_busy),
        .clr_wren (w_clr_wren),
        .clr_addr (w_clr_addr)
    );

    assign busy     = w_busy;
    assign w_wr_acc = wren & ~w_busy;
    assign w_rd_acc = rden & ~w_busy;

    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < width; b++)
            w_wmask[b] = byteena[b / BYTE_W];
    end

    // Sweep owns the write port while busy; user writes are dropped, not queued.
    always_ff @(posedge clk) begin
        if (w_clr_wren) begin
            r_mem[w_clr_addr] <= clear_value;
        end else if (w_wr_acc) begin
            for (int b = 0; b < width; b++)
                if (w_wmask[b])
                    r_mem[wraddress][b] <= data[b];
        end
    end

    assign w_rd_word = r_mem[rdaddress];

`ifdef SIMPLE_RAM_EX_BYPASS_EN
    assign w_rd_data = (w_wr_acc && (wraddress == rdaddress))
                     ? ((w_rd_word & ~w_wmask) | (data & w_wmask))
                     : w_rd_word;
`else
    assign w_rd_data = w_rd_word;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc)
                r_q1 <= w_rd_data;
        end
    end

    generate
        if (out_reg != 0) begin : g_out_reg
            logic [width-1:0] r_q2;
            logic             r_v2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1)
                        r_q2 <= r_q1;
                end
            end

            assign q       = r_q2;
            assign q_valid = r_v2;
        end else begin : g_no_out_reg
            assign q       = r_q1;
            assign q_valid = r_v1;
        end
    endgenerate

endmodule

// File: tb/tb_simple_ram_ex.sv
// Directed bench for simple_ram_ex: latency-1, latency-2 and no-sweep instances share stimulus.
module tb_simple_ram_ex;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wraddress, rdaddress;
    logic        wren, rden;
    logic [3:0]  byteena;
    logic [31:0] data;

    logic [31:0] q_a, q_b, q_c;
    logic        qv_a, qv_b, qv_c;
    logic        busy_a, busy_b, busy_c;

    int          checks = 0;
    int          errors = 0;
    int          n;
    logic [31:0] exp_mem [16];

    always #5 clk = ~clk;

    simple_ram_ex #(.width(32), .widthad(4), .out_reg(0), .clear_on_reset(1),
                    .clear_value(32'hDEAD_BEEF)) dut_a (
        .clk(clk), .rst(rst), .wraddress(wraddress), .wren(wren), .byteena(byteena),
        .data(data), .rdaddress(rdaddress), .rden(rden), .q(q_a), .q_valid(qv_a), .busy(busy_a));

    simple_ram_ex #(.width(32), .widthad(4), .out_reg(1), .clear_on_reset(1),
                    .clear_value(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .rst(rst), .wraddress(wraddress), .wren(wren), .byteena(byteena),
        .data(data), .rdaddress(rdaddress), .rden(rden), .q(q_b), .q_valid(qv_b), .busy(busy_b));

    simple_ram_ex #(.width(32), .widthad(4), .out_reg(0), .clear_on_reset(0),
                    .clear_value(32'hDEAD_BEEF)) dut_c (
        .clk(clk), .rst(rst), .wraddress(wraddress), .wren(wren), .byteena(byteena),
        .data(data), .rdaddress(rdaddress), .rden(rden), .q(q_c), .q_valid(qv_c), .busy(busy_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wren = 1'b1; wraddress = a; data = d; byteena = be;
        tick();
        wren = 1'b0;
    endtask

    task automatic wait_sweep(input string tag, input int start);
        n = start;
        while (busy_a && n < 40) begin
            tick();
            n++;
            chk({tag, "_qv_busy"}, qv_a, 1'b0);
        end
        chk({tag, "_busy_cycles"}, n, 16);
        chk({tag, "_busy_b"}, busy_b, 1'b0);
    endtask

    // Back-to-back reads of all 16 addresses, then rden low to check hold.
    task automatic burst(input string tag);
        for (int i = 0; i <= 17; i++) begin
            if (i < 16) begin
                rden = 1'b1;
                rdaddress = 4'(i);
            end else begin
                rden = 1'b0;
            end
            tick();
            if (i < 16) begin
                chk({tag, "_a_qv"}, qv_a, 1'b1);
                chk({tag, "_a_q"}, q_a, exp_mem[i]);
            end else begin
                chk({tag, "_a_qv_idle"}, qv_a, 1'b0);
                chk({tag, "_a_q_hold"}, q_a, exp_mem[15]);
            end
            if (i >= 1 && i <= 16) begin
                chk({tag, "_b_qv"}, qv_b, 1'b1);
                chk({tag, "_b_q"}, q_b, exp_mem[i-1]);
            end else if (i == 17) begin
                chk({tag, "_b_qv_idle"}, qv_b, 1'b0);
                chk({tag, "_b_q_hold"}, q_b, exp_mem[15]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; rden = 1'b0;
        wraddress = '0; rdaddress = '0; byteena = '0; data = '0;
        tick();
        tick();
        chk("rst_q", q_a, 32'h0);
        chk("rst_qv", qv_a, 1'b0);
        chk("rst_busy", busy_a, 1'b1);
        chk("rst_busy_noclr", busy_c, 1'b0);

        // Release; the no-sweep instance works at once while the others are busy.
        rst = 1'b0;
        chk("noclr_busy_release", busy_c, 1'b0);
        wr(4'd9, 32'h1234_5678, 4'hF);
        rden = 1'b1; rdaddress = 4'd9;
        tick();
        rden = 1'b0;
        chk("noclr_qv", qv_c, 1'b1);
        chk("noclr_q", q_c, 32'h1234_5678);
        chk("busy_drop_qv", qv_a, 1'b0);
        chk("busy_still", busy_a, 1'b1);
        wait_sweep("sweep1", 2);

        for (int i = 0; i < 16; i++) exp_mem[i] = 32'hDEAD_BEEF;
        burst("clear");

        // Lane-masked writes: lanes 0 and 2 replaced.
        wr(4'd3, 32'h1122_3344, 4'hF);
        wr(4'd3, 32'hAABB_CCDD, 4'b0101);
        wr(4'd3, 32'h0000_0000, 4'b0000);
        rden = 1'b1; rdaddress = 4'd3;
        tick();
        rden = 1'b0;
        chk("lane_a_qv", qv_a, 1'b1);
        chk("lane_a_q", q_a, 32'h11BB_33DD);
        chk("lane_b_qv_early", qv_b, 1'b0);
        tick();
        chk("lane_a_qv_off", qv_a, 1'b0);
        chk("lane_b_qv", qv_b, 1'b1);
        chk("lane_b_q", q_b, 32'h11BB_33DD);
        tick();

        // Same-cycle read and write at address 5.
        wren = 1'b1; wraddress = 4'd5; data = 32'hCAFE_F00D; byteena = 4'hF;
        rden = 1'b1; rdaddress = 4'd5;
        tick();
        wren = 1'b0;
`ifdef SIMPLE_RAM_EX_BYPASS_EN
        chk("same_addr_q", q_a, 32'hCAFE_F00D);
`else
        chk("same_addr_q", q_a, 32'hDEAD_BEEF);
`endif
        tick();
        rden = 1'b0;
        chk("same_addr_next", q_a, 32'hCAFE_F00D);
        tick();
        tick();

        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = 32'hA500_0000 + i * 32'h0001_0101;
            wr(4'(i), exp_mem[i], 4'hF);
        end
        tick();
        burst("b2b");

        // Reset mid-sweep, then strobes during the restarted sweep must be dropped.
        rst = 1'b1;
        tick();
        chk("rst2_q", q_a, 32'h0);
        chk("rst2_busy", busy_a, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_sweep_busy", busy_a, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wren = 1'b1; wraddress = 4'd1; data = 32'h5555_5555; byteena = 4'hF;
        rden = 1'b1; rdaddress = 4'd1;
        wait_sweep("sweep2", 0);
        wren = 1'b0; rden = 1'b0;
        tick();
        chk("sweep2_qv_b", qv_b, 1'b0);
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'hDEAD_BEEF;
        burst("clear2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
